// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 cracker stages.
// Holds the PRGA state encoding, message bounds and the printable-byte test.
package arc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LEN_RD = 4'd1,
      ST_LEN_WR = 4'd2,
      ST_RD_I   = 4'd3,
      ST_RD_J   = 4'd4,
      ST_WR_I   = 4'd5,
      ST_WR_J   = 4'd6,
      ST_RD_PAD = 4'd7,
      ST_WR_PT  = 4'd8
   } prga_state_t;

   localparam int         MSG_MAX      = 255;
   localparam logic [7:0] PRINT_LO_DEF = 8'h20;
   localparam logic [7:0] PRINT_HI_DEF = 8'h7E;

   function automatic logic is_printable(input logic [7:0] b,
                                         input logic [7:0] lo = PRINT_LO_DEF,
                                         input logic [7:0] hi = PRINT_HI_DEF);
      return (b >= lo) && (b <= hi);
   endfunction

endpackage

// File: rtl/arc4_prga_check.sv
// ARC4 PRGA + decrypt stage: walks the permuted S left by key scheduling,
// writes a length-prefixed plaintext and flags whether it is all printable.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | rdy=1, waiting for en
// LEN_RD    | address ciphertext length byte
// LEN_WR    | copy length to plaintext[0]; exit if length is zero
// RD_I      | read S[i], address ciphertext byte k
// RD_J      | j += S[i], read S[j]
// WR_I      | S[i] <= S[j], latch ciphertext byte
// WR_J      | S[j] <= old S[i]
// RD_PAD    | read S[S[i]+S[j]]
// WR_PT     | plaintext[k] <= pad ^ ct; loop, finish or abort
module arc4_prga_check
   import arc4_pkg::*;
#(
   parameter bit         ABORT_ON_INVALID = 1'b1,
   parameter logic [7:0] PRINT_LO         = PRINT_LO_DEF,
   parameter logic [7:0] PRINT_HI         = PRINT_HI_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic       valid,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] ct_addr,
   input  logic [7:0] ct_rddata,
   output logic [7:0] pt_addr,
   output logic [7:0] pt_wrdata,
   output logic       pt_wren
);

   prga_state_t r_state;
   logic [7:0]  r_i;
   logic [7:0]  r_j;
   logic [7:0]  r_k;
   logic [7:0]  r_len;
   logic [7:0]  r_si;
   logic [7:0]  r_sj;
   logic [7:0]  r_cb;
   logic        r_ok;
   logic        r_valid;

   logic [7:0]  w_j_next;
   logic [7:0]  w_pt_byte;
   logic        w_bad;
   logic        w_last;

   assign w_j_next  = r_j + s_rddata;
   assign w_pt_byte = s_rddata ^ r_cb;
   assign w_bad     = !is_printable(w_pt_byte, PRINT_LO, PRINT_HI);
   assign w_last    = (r_k == r_len) || (ABORT_ON_INVALID && w_bad);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_i     <= 8'd0;
         r_j     <= 8'd0;
         r_k     <= 8'd0;
         r_len   <= 8'd0;
         r_si    <= 8'd0;
         r_sj    <= 8'd0;
         r_cb    <= 8'd0;
         r_ok    <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  r_state <= ST_LEN_RD;
                  r_i     <= 8'd0;
                  r_j     <= 8'd0;
                  r_k     <= 8'd0;
                  r_ok    <= 1'b1;
                  r_valid <= 1'b0;
               end
            end
            ST_LEN_RD: r_state <= ST_LEN_WR;
            ST_LEN_WR: begin
               r_len <= ct_rddata;
               r_k   <= 8'd1;
               r_i   <= 8'd1;
               if (ct_rddata == 8'd0) begin
                  r_valid <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_RD_I;
               end
            end
            ST_RD_I: r_state <= ST_RD_J;
            ST_RD_J: begin
               r_si    <= s_rddata;
               r_j     <= w_j_next;
               r_state <= ST_WR_I;
            end
            ST_WR_I: begin
               r_sj    <= s_rddata;
               r_cb    <= ct_rddata;
               r_state <= ST_WR_J;
            end
            ST_WR_J:   r_state <= ST_RD_PAD;
            ST_RD_PAD: r_state <= ST_WR_PT;
            ST_WR_PT: begin
               if (w_bad)
                  r_ok <= 1'b0;
               if (w_last) begin
                  r_valid <= r_ok && !w_bad;
                  r_state <= ST_IDLE;
               end else begin
                  r_k     <= r_k + 8'd1;
                  r_i     <= r_i + 8'd1;
                  r_state <= ST_RD_I;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Ciphertext address is held at k through WR_I so the byte is still on the bus there.
   always_comb begin
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      ct_addr   = 8'd0;
      pt_addr   = 8'd0;
      pt_wrdata = 8'd0;
      pt_wren   = 1'b0;
      case (r_state)
         ST_LEN_WR: begin
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
         end
         ST_RD_I: begin
            s_addr  = r_i;
            ct_addr = r_k;
         end
         ST_RD_J: begin
            s_addr  = w_j_next;
            ct_addr = r_k;
         end
         ST_WR_I: begin
            s_addr   = r_i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            ct_addr  = r_k;
         end
         ST_WR_J: begin
            s_addr   = r_j;
            s_wrdata = r_si;
            s_wren   = 1'b1;
         end
         ST_RD_PAD: s_addr = r_si + r_sj;
         ST_WR_PT: begin
            pt_addr   = r_k;
            pt_wrdata = w_pt_byte;
            pt_wren   = 1'b1;
         end
         default: ;
      endcase
   end

   assign rdy   = (r_state == ST_IDLE);
   assign valid = r_valid;

endmodule

// File: tb/tb_arc4_prga_check.sv
// Directed bench for arc4_prga_check: two instances (abort on / abort off)
// share one set of behavioural S, ciphertext and plaintext memories.
module tb_arc4_prga_check;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic sel;
   logic mem_init;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] s_rddata, ct_rddata;
   logic       rdy0, valid0, s_wren0, pt_wren0;
   logic [7:0] s_addr0, s_wrdata0, ct_addr0, pt_addr0, pt_wrdata0;
   logic       rdy1, valid1, s_wren1, pt_wren1;
   logic [7:0] s_addr1, s_wrdata1, ct_addr1, pt_addr1, pt_wrdata1;

   logic       m_rdy, m_valid, m_s_wren, m_pt_wren;
   logic [7:0] m_s_addr, m_s_wrdata, m_ct_addr, m_pt_addr, m_pt_wrdata;

   logic [7:0] s_mem  [256];
   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   logic [7:0] ct_img [256];
   int s_wr_cnt    = 0;
   int pt_wr_cnt   = 0;
   int multi_cnt   = 0;
   int idle_wr_cnt = 0;

   always #5 clk = ~clk;

   arc4_prga_check #(.ABORT_ON_INVALID(1'b1)) dut_abort (
      .clk(clk), .rst_n(rst_n), .en(en & ~sel), .rdy(rdy0), .valid(valid0),
      .s_addr(s_addr0), .s_rddata(s_rddata), .s_wrdata(s_wrdata0), .s_wren(s_wren0),
      .ct_addr(ct_addr0), .ct_rddata(ct_rddata),
      .pt_addr(pt_addr0), .pt_wrdata(pt_wrdata0), .pt_wren(pt_wren0));

   arc4_prga_check #(.ABORT_ON_INVALID(1'b0)) dut_full (
      .clk(clk), .rst_n(rst_n), .en(en & sel), .rdy(rdy1), .valid(valid1),
      .s_addr(s_addr1), .s_rddata(s_rddata), .s_wrdata(s_wrdata1), .s_wren(s_wren1),
      .ct_addr(ct_addr1), .ct_rddata(ct_rddata),
      .pt_addr(pt_addr1), .pt_wrdata(pt_wrdata1), .pt_wren(pt_wren1));

   assign m_rdy       = sel ? rdy1       : rdy0;
   assign m_valid     = sel ? valid1     : valid0;
   assign m_s_addr    = sel ? s_addr1    : s_addr0;
   assign m_s_wrdata  = sel ? s_wrdata1  : s_wrdata0;
   assign m_s_wren    = sel ? s_wren1    : s_wren0;
   assign m_ct_addr   = sel ? ct_addr1   : ct_addr0;
   assign m_pt_addr   = sel ? pt_addr1   : pt_addr0;
   assign m_pt_wrdata = sel ? pt_wrdata1 : pt_wrdata0;
   assign m_pt_wren   = sel ? pt_wren1   : pt_wren0;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int n = 0; n < 256; n++) begin
            s_mem[n]  <= n[7:0];
            ct_mem[n] <= ct_img[n];
            pt_mem[n] <= 8'h00;
         end
         s_wr_cnt  <= 0;
         pt_wr_cnt <= 0;
      end else begin
         if (m_s_wren) begin
            s_mem[m_s_addr] <= m_s_wrdata;
            s_wr_cnt        <= s_wr_cnt + 1;
         end
         if (m_pt_wren) begin
            pt_mem[m_pt_addr] <= m_pt_wrdata;
            pt_wr_cnt         <= pt_wr_cnt + 1;
         end
         if (m_s_wren && m_pt_wren)
            multi_cnt <= multi_cnt + 1;
         if (m_rdy && (m_s_wren || m_pt_wren))
            idle_wr_cnt <= idle_wr_cnt + 1;
      end
      s_rddata  <= s_mem[m_s_addr];
      ct_rddata <= ct_mem[m_ct_addr];
   end

   task automatic prep(input logic [7:0] len, input logic [7:0] b1,
                       input logic [7:0] b2, input logic which);
      for (int n = 0; n < 256; n++) ct_img[n] = 8'h00;
      ct_img[0] = len;
      ct_img[1] = b1;
      ct_img[2] = b2;
      @(negedge clk);
      sel      = which;
      mem_init = 1'b1;
      @(negedge clk);
      mem_init = 1'b0;
   endtask

   task automatic run(output int lat);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      lat = 0;
      while (!m_rdy && lat < 2000) begin
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      compared++;
      if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_rdy: got %b/%b expected 1/1", rdy0, rdy1);
      end
      compared++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_valid: got %b/%b expected 0/0", valid0, valid1);
      end
      compared++;
      if ({s_wren0, pt_wren0, s_addr0, ct_addr0, pt_addr0, s_wrdata0, pt_wrdata0} !== 43'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got wren %b%b addr %h %h %h expected all zero",
                  s_wren0, pt_wren0, s_addr0, ct_addr0, pt_addr0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_one_byte;
      int lat;
      prep(8'd1, 8'h43, 8'h00, 1'b0);
      run(lat);
      compared++;
      if (lat !== 8) begin
         mismatched++;
         $display("FAIL one_byte_latency: got %0d expected 8", lat);
      end
      compared++;
      if (pt_mem[0] !== 8'h01 || pt_mem[1] !== 8'h41) begin
         mismatched++;
         $display("FAIL one_byte_pt: got %h %h expected 01 41", pt_mem[0], pt_mem[1]);
      end
      compared++;
      if (m_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL one_byte_valid: got %b expected 1", m_valid);
      end
      compared++;
      if (s_mem[1] !== 8'h01 || s_mem[2] !== 8'h02 || s_wr_cnt !== 2) begin
         mismatched++;
         $display("FAIL one_byte_s: got S1 %h S2 %h writes %0d expected 01 02 2",
                  s_mem[1], s_mem[2], s_wr_cnt);
      end
   endtask

   task automatic test_two_byte;
      int lat;
      int bad;
      logic [7:0] exp_s;
      prep(8'd2, 8'h43, 8'h47, 1'b0);
      run(lat);
      compared++;
      if (lat !== 14) begin
         mismatched++;
         $display("FAIL two_byte_latency: got %0d expected 14", lat);
      end
      compared++;
      if (pt_mem[0] !== 8'h02 || pt_mem[1] !== 8'h41 || pt_mem[2] !== 8'h42) begin
         mismatched++;
         $display("FAIL two_byte_pt: got %h %h %h expected 02 41 42",
                  pt_mem[0], pt_mem[1], pt_mem[2]);
      end
      compared++;
      if (m_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL two_byte_valid: got %b expected 1", m_valid);
      end
      bad = 0;
      for (int n = 0; n < 256; n++) begin
         exp_s = n[7:0];
         if (n == 2) exp_s = 8'd3;
         if (n == 3) exp_s = 8'd2;
         if (s_mem[n] !== exp_s) bad++;
      end
      compared++;
      if (bad != 0 || s_mem[2] !== 8'd3 || s_mem[3] !== 8'd2) begin
         mismatched++;
         $display("FAIL two_byte_s: got %0d wrong entries S2 %h S3 %h expected 0 03 02",
                  bad, s_mem[2], s_mem[3]);
      end
   endtask

   task automatic test_abort;
      int lat;
      prep(8'd2, 8'h02, 8'h47, 1'b0);
      run(lat);
      compared++;
      if (lat !== 8) begin
         mismatched++;
         $display("FAIL abort_latency: got %0d expected 8", lat);
      end
      compared++;
      if (pt_mem[1] !== 8'h00 || pt_wr_cnt !== 2) begin
         mismatched++;
         $display("FAIL abort_pt: got pt1 %h writes %0d expected 00 2", pt_mem[1], pt_wr_cnt);
      end
      compared++;
      if (m_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL abort_valid: got %b expected 0", m_valid);
      end
   endtask

   task automatic test_no_abort;
      int lat;
      prep(8'd2, 8'h02, 8'h47, 1'b1);
      run(lat);
      compared++;
      if (lat !== 14) begin
         mismatched++;
         $display("FAIL full_latency: got %0d expected 14", lat);
      end
      compared++;
      if (pt_mem[0] !== 8'h02 || pt_mem[1] !== 8'h00 || pt_mem[2] !== 8'h42 || pt_wr_cnt !== 3) begin
         mismatched++;
         $display("FAIL full_pt: got %h %h %h writes %0d expected 02 00 42 3",
                  pt_mem[0], pt_mem[1], pt_mem[2], pt_wr_cnt);
      end
      compared++;
      if (m_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL full_valid: got %b expected 0", m_valid);
      end
   endtask

   task automatic test_zero_len;
      int lat;
      prep(8'd0, 8'h00, 8'h00, 1'b0);
      run(lat);
      compared++;
      if (lat !== 2) begin
         mismatched++;
         $display("FAIL zero_latency: got %0d expected 2", lat);
      end
      compared++;
      if (pt_wr_cnt !== 1 || s_wr_cnt !== 0 || pt_mem[0] !== 8'h00) begin
         mismatched++;
         $display("FAIL zero_writes: got pt %0d s %0d pt0 %h expected 1 0 00",
                  pt_wr_cnt, s_wr_cnt, pt_mem[0]);
      end
      compared++;
      if (m_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL zero_valid: got %b expected 1", m_valid);
      end
   endtask

   task automatic test_en_held;
      int lat;
      int lat2;
      prep(8'd1, 8'h43, 8'h00, 1'b0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!m_rdy && lat < 2000) begin
         lat++;
         @(negedge clk);
      end
      compared++;
      if (lat !== 8 || pt_wr_cnt !== 2) begin
         mismatched++;
         $display("FAIL held_first_run: got lat %0d writes %0d expected 8 2", lat, pt_wr_cnt);
      end
      @(negedge clk);
      en = 1'b0;
      compared++;
      if (m_rdy !== 1'b0) begin
         mismatched++;
         $display("FAIL held_restart: got rdy %b expected 0", m_rdy);
      end
      lat2 = 0;
      while (!m_rdy && lat2 < 2000) begin
         lat2++;
         @(negedge clk);
      end
      compared++;
      if (lat2 !== 8 || pt_wr_cnt !== 4 || pt_mem[1] !== 8'h41 || m_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL held_second_run: got lat %0d writes %0d pt1 %h valid %b expected 8 4 41 1",
                  lat2, pt_wr_cnt, pt_mem[1], m_valid);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      int wcnt;
      prep(8'd2, 8'h43, 8'h47, 1'b0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      cyc  = 0;
      wcnt = 0;
      while (cyc < 100) begin
         if (m_s_wren) wcnt++;
         if (wcnt == 2) break;
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (wcnt != 2) begin
         mismatched++;
         $display("FAIL mid_reach_wr_j: got %0d S writes expected 2", wcnt);
      end
      rst_n = 1'b0;
      #1;
      compared++;
      if (m_rdy !== 1'b1 || m_valid !== 1'b0 || m_s_wren !== 1'b0 || m_pt_wren !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_reset: got rdy %b valid %b wren %b%b expected 1 0 00",
                  m_rdy, m_valid, m_s_wren, m_pt_wren);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      sel      = 1'b0;
      mem_init = 1'b0;
      for (int n = 0; n < 256; n++) ct_img[n] = 8'h00;
      test_reset;
      test_one_byte;
      test_two_byte;
      test_abort;
      test_no_abort;
      test_zero_len;
      test_en_held;
      test_reset_mid;
      test_two_byte;
      compared++;
      if (multi_cnt !== 0 || idle_wr_cnt !== 0) begin
         mismatched++;
         $display("FAIL write_rules: got multi %0d idle %0d expected 0 0", multi_cnt, idle_wr_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
